// File: rtl/aes_key_sequencer.sv
// AES key sequencer: snapshots plaintext and key pointer, fetches a 128-bit key over req/ack, launches the core and returns the result.
// Optional macro AES_TIMEOUT_EN adds a WAIT watchdog that aborts with an all-ones result and a sticky aes_err.
module aes_key_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_STRIDE    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  key_addr,
    input  logic [31:0]  din0,
    input  logic [31:0]  din1,
    input  logic [31:0]  din2,
    input  logic [31:0]  din3,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
    output logic         aes_start,
    output logic [127:0] aes_key,
    output logic [127:0] aes_block,
    input  logic         core_done,
    input  logic [127:0] core_res,
    output logic [31:0]  res0,
    output logic [31:0]  res1,
    output logic [31:0]  res2,
    output logic [31:0]  res3,
    output logic         aes_done,
    output logic         busy,
    output logic         aes_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [31:0]    base_q, base_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   block_q, block_d;
    logic [127:0]   res_q, res_d;

`ifdef AES_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
`endif

    // Low address bits are dropped: key fetches are always word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^key_addr[1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        key_d   = key_q;
        block_d = block_q;
        res_d   = res_q;
`ifdef AES_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    block_d = {din0, din1, din2, din3};
                    base_d  = {key_addr[31:2], 2'b00};
                    idx_d   = '0;
`ifdef AES_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    case (idx_q)
                        2'd0:    key_d[127:96] = mem_rdata;
                        2'd1:    key_d[95:64]  = mem_rdata;
                        2'd2:    key_d[63:32]  = mem_rdata;
                        default: key_d[31:0]   = mem_rdata;
                    endcase
                    if (idx_q == 2'd3) begin
                        state_d = S_LAUNCH;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_LAUNCH: begin
`ifdef AES_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A core_done coinciding with the last watchdog cycle still delivers the real result.
                if (core_done) begin
                    res_d   = core_res;
                    state_d = S_DONE;
`ifdef AES_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = '1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            key_q   <= '0;
            block_q <= '0;
            res_q   <= '0;
`ifdef AES_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            key_q   <= key_d;
            block_q <= block_d;
            res_q   <= res_d;
`ifdef AES_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem_req   = (state_q == S_FETCH);
    assign mem_addr  = (state_q == S_FETCH) ? base_q + 32'(idx_q) * ADDR_STRIDE : '0;
    assign aes_start = (state_q == S_LAUNCH);
    assign aes_done  = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign aes_key   = key_q;
    assign aes_block = block_q;
    assign res0      = res_q[127:96];
    assign res1      = res_q[95:64];
    assign res2      = res_q[63:32];
    assign res3      = res_q[31:0];

`ifdef AES_TIMEOUT_EN
    assign aes_err   = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
    assign aes_err   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_sequencer.sv
// Bench for aes_key_sequencer: directed transactions drive a cycle-level expectation model checked every cycle.
// Build with AES_TIMEOUT_EN to exercise the watchdog path; otherwise WAIT must hang until reset.
`timescale 1ns/1ps
module tb_aes_key_sequencer;

    localparam int unsigned TMO = 16;

    logic         clk = 1'b0;
    logic         rst, start, mem_ack, core_done;
    logic [31:0]  key_addr, din0, din1, din2, din3, mem_rdata;
    logic [127:0] core_res;
    logic         mem_req, aes_start, aes_done, busy, aes_err;
    logic [31:0]  mem_addr, res0, res1, res2, res3;
    logic [127:0] aes_key, aes_block;

    always #5 clk = ~clk;

    aes_key_sequencer #(.TIMEOUT_CYCLES(TMO), .ADDR_STRIDE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .key_addr(key_addr),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .aes_start(aes_start), .aes_key(aes_key), .aes_block(aes_block),
        .core_done(core_done), .core_res(core_res),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3),
        .aes_done(aes_done), .busy(busy), .aes_err(aes_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected DUT outputs for the current cycle, maintained by the stimulus thread.
    logic         e_busy = 1'b0, e_req = 1'b0, e_start = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [31:0]  e_addr = '0;
    logic [127:0] e_key = '0, e_block = '0, e_res = '0;
    bit           chk_en = 1'b0;

    int           done_cnt = 0, start_seen = -1, done_seen = -1;
    logic [31:0]  acked[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 128'(busy), 128'(e_busy));
            chk("mem_req", 128'(mem_req), 128'(e_req));
            if (e_req) chk("mem_addr", 128'(mem_addr), 128'(e_addr));
            chk("aes_start", 128'(aes_start), 128'(e_start));
            chk("aes_done", 128'(aes_done), 128'(e_done));
            chk("aes_err", 128'(aes_err), 128'(e_err));
            chk("aes_key", aes_key, e_key);
            chk("aes_block", aes_block, e_block);
            chk("res", {res0, res1, res2, res3}, e_res);
            if (mem_req && mem_ack) acked.push_back(mem_addr);
            if (aes_done) begin done_cnt++; done_seen = cyc; end
            if (aes_start) start_seen = cyc;
        end
    end

    function automatic logic [31:0] word_of(input logic [127:0] v, input int w);
        logic [127:0] t;
        t = v >> (32 * (3 - w));
        return t[31:0];
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] v, input int w, input logic [31:0] x);
        logic [127:0] m;
        m = {96'b0, 32'hFFFF_FFFF} << (32 * (3 - w));
        return (v & ~m) | ({96'b0, x} << (32 * (3 - w)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e_busy = 0; e_req = 0; e_start = 0; e_done = 0; e_err = 0;
        e_key = '0; e_block = '0; e_res = '0;
    endtask

    // core_wait < 0 means core_done never arrives.
    task automatic do_op(input logic [127:0] blk, input logic [31:0] kaddr, input logic [127:0] key,
                         input int ack_wait, input int core_wait, input logic [127:0] cres,
                         input bit poke_fetch, input bit poke_wait, input int exp_lat);
        int t0, w0, d0;
        logic [31:0] base;
        bit hung;
        hung = 1'b0;
        base = {kaddr[31:2], 2'b00};
        d0 = done_cnt;
        acked.delete();
        t0 = cyc;
        start = 1'b1;
        {din0, din1, din2, din3} = blk;
        key_addr = kaddr;
        tick();
        start = 1'b0;
        e_busy = 1; e_block = blk; e_err = 0;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k <= ack_wait; k++) begin
                e_req = 1;
                e_addr = base + 32'(w * 4);
                mem_ack = (k == ack_wait);
                mem_rdata = mem_ack ? word_of(key, w) : 32'hDEAD_BEEF;
                if (poke_fetch && w == 0 && k == 0) begin
                    start = 1'b1;
                    {din0, din1, din2, din3} = ~blk;
                    core_done = 1'b1;
                    core_res = ~cres;
                end
                tick();
                start = 1'b0; core_done = 1'b0; mem_ack = 1'b0;
                if (k == ack_wait) e_key = put_word(e_key, w, word_of(key, w));
            end
        end
        e_req = 0; e_start = 1;
        tick();
        e_start = 0;
        w0 = cyc;
        chk("start_latency", 128'(start_seen - t0), 128'(exp_lat));
        if (core_wait >= 0) begin
            for (int k = 0; k <= core_wait; k++) begin
                if (k == core_wait) begin core_done = 1'b1; core_res = cres; end
                if (poke_wait && k == 0) begin start = 1'b1; din0 = ~din0; end
                tick();
                core_done = 1'b0; start = 1'b0;
            end
            e_res = cres; e_done = 1;
        end else begin
`ifdef AES_TIMEOUT_EN
            for (int k = 0; k < int'(TMO); k++) tick();
            e_res = '1; e_err = 1; e_done = 1;
`else
            for (int k = 0; k < 40; k++) tick();
            do_reset();
            hung = 1'b1;
`endif
        end
        if (!hung) begin
            tick();
            e_done = 0; e_busy = 0;
            if (core_wait >= 0) chk("done_latency", 128'(done_seen - (w0 + core_wait)), 128'(1));
            else chk("tmo_latency", 128'(done_seen - w0), 128'(TMO));
            chk("done_count", 128'(done_cnt - d0), 128'(1));
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; key_addr = '0; din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        mem_ack = 0; mem_rdata = '0; core_done = 0; core_res = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_res0", 128'(res0), 128'(0));

        // Basic run with zero-wait ack.
        do_op(128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h1000,
              128'h00010203_04050607_08090A0B_0C0D0E0F, 0, 3,
              128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A, 0, 0, 5);
        chk("basic_res0", 128'(res0), 128'(32'h69C4E0D8));
        chk("basic_res3", 128'(res3), 128'(32'h70B4C55A));
        chk("basic_key", aes_key, 128'h00010203_04050607_08090A0B_0C0D0E0F);
        chk("basic_block", aes_block, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("basic_nacks", 128'(acked.size()), 128'(4));
        chk("basic_addr0", 128'(acked[0]), 128'(32'h1000));
        chk("basic_addr1", 128'(acked[1]), 128'(32'h1004));
        chk("basic_addr2", 128'(acked[2]), 128'(32'h1008));
        chk("basic_addr3", 128'(acked[3]), 128'(32'h100C));

        // Wait states and misaligned key pointer.
        do_op(128'hA5A5A5A5_11111111_22222222_33333333, 32'h1003,
              128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF, 3, 0,
              128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 0, 17);
        chk("mis_addr0", 128'(acked[0]), 128'(32'h1000));
        chk("mis_addr3", 128'(acked[3]), 128'(32'h100C));

        // Second start and stray core_done while busy.
        do_op(128'h0BADC0DE_12345678_9ABCDEF0_0FEDCBA9, 32'hFFFF_FFF8,
              128'h11223344_55667788_99AABBCC_DDEEFF00, 1, 2,
              128'h13579BDF_2468ACE0_FDB97531_0ECA8642, 1, 1, 9);
        chk("busy_block", aes_block, 128'h0BADC0DE_12345678_9ABCDEF0_0FEDCBA9);
        chk("wrap_addr2", 128'(acked[2]), 128'(32'h0000_0000));

        // Spurious core_done in IDLE.
        begin
            int d0;
            d0 = done_cnt;
            core_done = 1'b1; core_res = '1;
            tick();
            core_done = 1'b0;
            tick(); tick();
            chk("spur_done_count", 128'(done_cnt - d0), 128'(0));
            chk("spur_res0", 128'(res0), 128'(32'h13579BDF));
        end

        // Reset while fetching word 2, then a stray ack.
        begin
            logic [127:0] key;
            key = 128'h01010101_02020202_03030303_04040404;
            start = 1'b1; key_addr = 32'h2000;
            {din0, din1, din2, din3} = 128'h5;
            tick();
            start = 1'b0;
            e_busy = 1; e_block = 128'h5; e_err = 0;
            for (int w = 0; w < 2; w++) begin
                e_req = 1; e_addr = 32'h2000 + 32'(w * 4);
                mem_ack = 1'b1; mem_rdata = word_of(key, w);
                tick();
                mem_ack = 1'b0;
                e_key = put_word(e_key, w, word_of(key, w));
            end
            e_req = 1; e_addr = 32'h2008;
            do_reset();
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_req", 128'(mem_req), 128'(0));
            mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            tick();
            mem_ack = 1'b0;
            tick();
            chk("stray_key", aes_key, 128'h0);
        end

        // Normal operation after reset.
        do_op(128'h1, 32'h40, 128'h2, 0, 1, 128'h3, 0, 0, 5);

        // Core never answers.
        do_op(128'hFEEDFACE_00000000_11111111_22222222, 32'h80,
              128'h33333333_44444444_55555555_66666666, 0, -1, 128'h0, 0, 0, 5);
`ifdef AES_TIMEOUT_EN
        chk("tmo_res0", 128'(res0), 128'(32'hFFFF_FFFF));
        chk("tmo_err", 128'(aes_err), 128'(1));
        // core_done on the final watchdog cycle wins.
        do_op(128'h7, 32'h90, 128'h8, 0, int'(TMO) - 1, 128'h9ABC, 0, 0, 5);
        chk("race_err", 128'(aes_err), 128'(0));
        chk("race_res3", 128'(res3), 128'(32'h9ABC));
`else
        chk("hang_busy_after_reset", 128'(busy), 128'(0));
        chk("hang_err", 128'(aes_err), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
